// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller.
package intc_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } intc_state_t;

    localparam int unsigned DefaultNumSrc = 8;
    localparam logic [31:0] EnMaskRst     = '1;

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational priority encoder: lowest set request index wins.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int unsigned NUM_SRC = DefaultNumSrc,
    parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    always_comb begin
        valid = |req;
        id    = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// Edge-triggered, fixed-priority interrupt controller with take/return handshake.
// Define INTC_SYNC_EN to add a 2-flop synchronizer on every irq_src line.
module int_controller
    import intc_pkg::*;
#(
    parameter int unsigned NUM_SRC = DefaultNumSrc,
    parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               en_we,
    input  logic [NUM_SRC-1:0] en_wdata,
    input  logic               int_ack,
    input  logic               int_ret,
    output logic               interupt,
    output logic [ID_W-1:0]    int_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending
);

    logic [NUM_SRC-1:0] src_s;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] src_rise;
    logic [NUM_SRC-1:0] en_mask;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] ack_clr;
    logic               req_valid;
    logic [ID_W-1:0]    req_id;
    logic               take;
    intc_state_t        state;

`ifdef INTC_SYNC_EN
    logic [NUM_SRC-1:0] sync_q1;
    logic [NUM_SRC-1:0] sync_q2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_src;
            sync_q2 <= sync_q1;
        end
    end

    assign src_s = sync_q2;
`else
    assign src_s = irq_src;
`endif

    assign src_rise = src_s & ~src_q;
    assign req      = pending & en_mask;
    assign take     = (state == IDLE) && interupt && int_ack;
    assign ack_clr  = take ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << int_id) : '0;

    intc_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req   (req),
        .valid (req_valid),
        .id    (req_id)
    );

    // A new edge on the acked source wins over its clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q   <= '0;
            pending <= '0;
            en_mask <= EnMaskRst[NUM_SRC-1:0];
        end else begin
            src_q   <= src_s;
            pending <= (pending & ~ack_clr) | src_rise;
            if (en_we) begin
                en_mask <= en_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            interupt   <= 1'b0;
            int_id     <= '0;
            in_service <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (interupt) begin
                        if (int_ack) begin
                            interupt   <= 1'b0;
                            in_service <= 1'b1;
                            state      <= SERVICE;
                        end else if (!en_mask[int_id]) begin
                            // Captured source got masked: withdraw and re-arbitrate.
                            interupt <= 1'b0;
                        end
                    end else if (req_valid) begin
                        interupt <= 1'b1;
                        int_id   <= req_id;
                    end
                end
                SERVICE: begin
                    if (int_ret) begin
                        in_service <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: vector table, hand sequences, random vs model.
module tb_int_controller;

    localparam int N = 8;
    localparam int W = 3;
`ifdef INTC_SYNC_EN
    localparam int Lat = 4;
`else
    localparam int Lat = 2;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq_src;
    logic         en_we;
    logic [N-1:0] en_wdata;
    logic         int_ack;
    logic         int_ret;
    logic         interupt;
    logic [W-1:0] int_id;
    logic         in_service;
    logic [N-1:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    int_controller #(
        .NUM_SRC (N),
        .ID_W    (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irq_src),
        .en_we      (en_we),
        .en_wdata   (en_wdata),
        .int_ack    (int_ack),
        .int_ret    (int_ret),
        .interupt   (interupt),
        .int_id     (int_id),
        .in_service (in_service),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    // Reference model: pending set, mask, busy flag, request flag, captured id.
    bit [N-1:0] m_prev, m_pend, m_mask;
    bit         m_busy, m_irq;
    int         m_id;
`ifdef INTC_SYNC_EN
    bit [N-1:0] m_s1, m_s2;
`endif

    function automatic void model_reset();
        m_prev = '0;
        m_pend = '0;
        m_mask = '1;
        m_busy = 1'b0;
        m_irq  = 1'b0;
        m_id   = 0;
`ifdef INTC_SYNC_EN
        m_s1 = '0;
        m_s2 = '0;
`endif
    endfunction

    function automatic void model_step();
        bit [N-1:0] src, rise, np;
        int         win;
`ifdef INTC_SYNC_EN
        src  = m_s2;
        m_s2 = m_s1;
        m_s1 = irq_src;
`else
        src = irq_src;
`endif
        rise = src & ~m_prev;
        np   = m_pend;
        if (!m_busy && m_irq && int_ack) np[m_id] = 1'b0;
        np |= rise;
        if (m_busy) begin
            if (int_ret) m_busy = 1'b0;
        end else if (m_irq) begin
            if (int_ack) begin
                m_irq  = 1'b0;
                m_busy = 1'b1;
            end else if (!m_mask[m_id]) begin
                m_irq = 1'b0;
            end
        end else begin
            win = -1;
            for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
            if (win >= 0) begin
                m_irq = 1'b1;
                m_id  = win;
            end
        end
        if (en_we) m_mask = en_wdata;
        m_pend = np;
        m_prev = src;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        irq_src  = '0;
        en_we    = 1'b0;
        en_wdata = '0;
        int_ack  = 1'b0;
        int_ret  = 1'b0;
    endtask

    task automatic check_model();
        check("m_interupt", {31'd0, interupt}, {31'd0, m_irq});
        check("m_in_service", {31'd0, in_service}, {31'd0, m_busy});
        check("m_pending", {24'd0, pending}, {24'd0, m_pend});
        if (m_irq || m_busy) check("m_int_id", {29'd0, int_id}, m_id);
    endtask

    typedef struct {
        logic [7:0] irq;
        logic       we;
        logic [7:0] wd;
        logic       ack;
        logic       ret;
        logic       x_int;
        logic       x_svc;
        logic [7:0] x_pend;
        logic [2:0] x_id;
    } vec_t;

    vec_t tbl[$];
    int   cnt;

    initial begin
        idle_inputs();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_interupt", {31'd0, interupt}, 32'd0);
        check("rst_in_service", {31'd0, in_service}, 32'd0);
        check("rst_pending", {24'd0, pending}, 32'd0);
        check("rst_int_id", {29'd0, int_id}, 32'd0);
        rst = 1'b1;

`ifndef INTC_SYNC_EN
        // irq, we, wdata, ack, ret | interupt, in_service, pending, id
        tbl.push_back('{8'h08, 0, 8'h00, 0, 0, 0, 0, 8'h08, 3'd0});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h08, 3'd3});
        tbl.push_back('{8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h00, 3'd3});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h00, 3'd3});
        tbl.push_back('{8'h24, 0, 8'h00, 0, 0, 0, 0, 8'h24, 3'd0});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h24, 3'd2});
        tbl.push_back('{8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h20, 3'd2});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h20, 3'd2});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h20, 3'd5});
        tbl.push_back('{8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h00, 3'd5});
        tbl.push_back('{8'h01, 0, 8'h00, 0, 0, 0, 1, 8'h01, 3'd5});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h01, 3'd5});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h01, 3'd0});
        tbl.push_back('{8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h00, 3'd0});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h00, 3'd0});
        tbl.push_back('{8'h00, 1, 8'hF7, 0, 0, 0, 0, 8'h00, 3'd0});
        tbl.push_back('{8'h08, 0, 8'h00, 0, 0, 0, 0, 8'h08, 3'd0});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h08, 3'd0});
        tbl.push_back('{8'h00, 1, 8'hFF, 0, 0, 0, 0, 8'h08, 3'd0});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h08, 3'd3});
        tbl.push_back('{8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h00, 3'd3});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h00, 3'd3});
        tbl.push_back('{8'h10, 0, 8'h00, 0, 0, 0, 0, 8'h10, 3'd0});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h10, 3'd4});
        tbl.push_back('{8'h10, 0, 8'h00, 1, 0, 0, 1, 8'h10, 3'd4});
        tbl.push_back('{8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h10, 3'd4});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h10, 3'd4});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h10, 3'd4});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 1, 1, 0, 8'h10, 3'd4});
        tbl.push_back('{8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h00, 3'd4});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h00, 3'd4});
        tbl.push_back('{8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 3'd0});
        tbl.push_back('{8'h40, 0, 8'h00, 0, 0, 0, 0, 8'h40, 3'd0});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h40, 3'd6});
        tbl.push_back('{8'h00, 1, 8'hBF, 0, 0, 1, 0, 8'h40, 3'd6});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h40, 3'd0});
        tbl.push_back('{8'h02, 0, 8'h00, 0, 0, 0, 0, 8'h42, 3'd0});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h42, 3'd1});
        tbl.push_back('{8'h00, 1, 8'hFF, 1, 0, 0, 1, 8'h40, 3'd1});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h40, 3'd1});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h40, 3'd6});
        tbl.push_back('{8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h00, 3'd6});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h00, 3'd6});
        tbl.push_back('{8'h80, 0, 8'h00, 0, 0, 0, 0, 8'h80, 3'd0});
        tbl.push_back('{8'h80, 0, 8'h00, 0, 0, 1, 0, 8'h80, 3'd7});
        tbl.push_back('{8'h80, 0, 8'h00, 1, 0, 0, 1, 8'h00, 3'd7});
        tbl.push_back('{8'h80, 0, 8'h00, 0, 1, 0, 0, 8'h00, 3'd7});
        tbl.push_back('{8'h80, 0, 8'h00, 0, 0, 0, 0, 8'h00, 3'd0});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 3'd0});
        tbl.push_back('{8'h00, 1, 8'h00, 0, 0, 0, 0, 8'h00, 3'd0});
        tbl.push_back('{8'h0F, 0, 8'h00, 0, 0, 0, 0, 8'h0F, 3'd0});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h0F, 3'd0});
        tbl.push_back('{8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'hFF, 3'd0});
        tbl.push_back('{8'h00, 1, 8'hFF, 0, 0, 0, 0, 8'hFF, 3'd0});
        tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hFF, 3'd0});
        tbl.push_back('{8'h00, 0, 8'h00, 1, 0, 0, 1, 8'hFE, 3'd0});
        tbl.push_back('{8'h00, 1, 8'h00, 0, 0, 0, 1, 8'hFE, 3'd0});

        foreach (tbl[k]) begin
            irq_src  = tbl[k].irq;
            en_we    = tbl[k].we;
            en_wdata = tbl[k].wd;
            int_ack  = tbl[k].ack;
            int_ret  = tbl[k].ret;
            tick();
            check($sformatf("v%0d_interupt", k), {31'd0, interupt}, {31'd0, tbl[k].x_int});
            check($sformatf("v%0d_in_service", k), {31'd0, in_service}, {31'd0, tbl[k].x_svc});
            check($sformatf("v%0d_pending", k), {24'd0, pending}, {24'd0, tbl[k].x_pend});
            if (tbl[k].x_int || tbl[k].x_svc)
                check($sformatf("v%0d_int_id", k), {29'd0, int_id}, {29'd0, tbl[k].x_id});
        end
`endif

        // Asynchronous reset in the middle of a cycle while a handler may be running.
        idle_inputs();
        #2;
        rst = 1'b0;
        #1;
        check("async_interupt", {31'd0, interupt}, 32'd0);
        check("async_in_service", {31'd0, in_service}, 32'd0);
        check("async_pending", {24'd0, pending}, 32'd0);
        check("async_int_id", {29'd0, int_id}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Source edge to interupt latency; also shows en_mask reset to all ones.
        irq_src = 8'h08;
        cnt     = 0;
        do begin
            tick();
            irq_src = '0;
            cnt++;
        end while (!interupt && cnt < 10);
        check("latency", cnt, Lat);
        check("lat_int_id", {29'd0, int_id}, 32'd3);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("lat_ack_interupt", {31'd0, interupt}, 32'd0);
        check("lat_ack_in_service", {31'd0, in_service}, 32'd1);
        check("lat_ack_pending3", {31'd0, pending[3]}, 32'd0);
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        check_model();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            irq_src  = irq_src ^ N'($urandom & $urandom & $urandom);
            en_we    = ($urandom_range(0, 15) == 0);
            en_wdata = N'($urandom | $urandom);
            int_ack  = ($urandom_range(0, 2) == 0);
            int_ret  = ($urandom_range(0, 3) == 0);
            tick();
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
